// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that shares one multi-cycle ALU among
// NUM_REQ requesters. One operation is in flight at a time; the result is
// masked to the operation's natural width and strobed back to the winner.
//
// state | meaning
// IDLE  | searching req_valid from last_grant+1; winner is accepted on the edge
// ISSUE | alu_op_start high for this single cycle; wait counter gets loaded
// WAIT  | counting down the ALU latency; result captured when counter hits 1
// RESP  | rsp_valid[grant_id] strobed for one cycle, then back to IDLE
module alu_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ALU_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [2*NUM_REQ-1:0]       req_operation,
  input  logic [8*NUM_REQ-1:0]       req_operand_a,
  input  logic [8*NUM_REQ-1:0]       req_operand_b,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [15:0]                rsp_result,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       alu_op_start,
  output logic [1:0]                 alu_operation,
  output logic [7:0]                 alu_operand_a,
  output logic [7:0]                 alu_operand_b,
  input  logic [15:0]                alu_result
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ALU_LATENCY + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT = NUM_REQ'(1);
  localparam logic [ID_W-1:0]    LAST_ID = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_MUL, OP_OR, OP_AND} operation_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  winner;
  logic             found;
  logic [15:0]      masked_result;

  logic [1:0] op_arr [NUM_REQ];
  logic [7:0] a_arr  [NUM_REQ];
  logic [7:0] b_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g] = req_operation[2*g+1:2*g];
    assign a_arr[g]  = req_operand_a[8*g+7:8*g];
    assign b_arr[g]  = req_operand_b[8*g+7:8*g];
  end

  // Rotating-priority search: first valid requester after the last one served.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // Accept is offered only while idle, so it can never overlap a response.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) begin
      req_ready = ONE_HOT << winner;
    end
  end

  // Trim the ALU result to the width the operation can actually produce.
  always_comb begin
    masked_result = alu_result;
    case (operation_t'(alu_operation))
      OP_ADD:  masked_result = {7'b0, alu_result[8:0]};
      OP_MUL:  masked_result = alu_result;
      OP_OR,
      OP_AND:  masked_result = {8'b0, alu_result[7:0]};
      default: masked_result = alu_result;
    endcase
  end

  // Sequencing FSM; every output except req_ready is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      last_grant    <= LAST_ID;
      grant_id      <= '0;
      busy          <= 1'b0;
      alu_op_start  <= 1'b0;
      alu_operation <= '0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      rsp_valid     <= '0;
      rsp_result    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            alu_operation <= op_arr[winner];
            alu_operand_a <= a_arr[winner];
            alu_operand_b <= b_arr[winner];
            grant_id      <= winner;
            last_grant    <= winner;
            busy          <= 1'b1;
            alu_op_start  <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          alu_op_start <= 1'b0;
          wait_cnt     <= CNT_W'(ALU_LATENCY);
          state        <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == CNT_W'(1)) begin
            rsp_result <= masked_result;
            rsp_valid  <= ONE_HOT << grant_id;
            state      <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed requests with hand-computed results, an ALU
// model with the configured latency and junk in unused result bits, and a
// negedge monitor that checks accepts and responses against scoreboard queues.
module tb_alu_arbiter;

  localparam int N   = 4;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [2*N-1:0] req_operation = '0;
  logic [8*N-1:0] req_operand_a = '0;
  logic [8*N-1:0] req_operand_b = '0;
  logic [N-1:0]   rsp_valid;
  logic [15:0]    rsp_result;
  logic           busy;
  logic [1:0]     grant_id;
  logic           alu_op_start;
  logic [1:0]     alu_operation;
  logic [7:0]     alu_operand_a;
  logic [7:0]     alu_operand_b;
  logic [15:0]    alu_result;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N), .ALU_LATENCY(LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_operation (req_operation),
    .req_operand_a (req_operand_a),
    .req_operand_b (req_operand_b),
    .rsp_valid     (rsp_valid),
    .rsp_result    (rsp_result),
    .busy          (busy),
    .grant_id      (grant_id),
    .alu_op_start  (alu_op_start),
    .alu_operation (alu_operation),
    .alu_operand_a (alu_operand_a),
    .alu_operand_b (alu_operand_b),
    .alu_result    (alu_result)
  );

  // ALU model: result appears LAT edges after op_start is sampled; unused
  // upper bits carry junk so that missing masks show up.
  function automatic logic [15:0] alu_model(input logic [1:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      2'd0:    return {7'h2A, s};
      2'd1:    return 16'(a) * 16'(b);
      2'd2:    return {8'hAB, a | b};
      default: return {8'hAB, a & b};
    endcase
  endfunction

  logic [15:0] st0 = 16'hDEAD;
  logic [15:0] st1 = 16'hDEAD;
  always @(posedge clk) begin
    st0 <= alu_op_start ? alu_model(alu_operation, alu_operand_a, alu_operand_b) : 16'hDEAD;
    st1 <= st0;
  end
  assign alu_result = st1;

  typedef struct {
    int          idx;
    logic [15:0] res;
  } rsp_t;

  rsp_t exp_rsp[$];
  int   exp_grant[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_accept = 0;
  int acc_cyc = 0;
  bit have_acc = 1'b0;
  bit acc_prev = 1'b0;
  bit spacing_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int i, input logic [15:0] r);
    rsp_t e;
    e.idx = i;
    e.res = r;
    exp_grant.push_back(i);
    exp_rsp.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b);
    req_operation[2*i +: 2] = op;
    req_operand_a[8*i +: 8] = a;
    req_operand_b[8*i +: 8] = b;
    req_valid[i]            = 1'b1;
  endtask

  // Monitor: compares every accept and every response against the queues.
  always @(negedge clk) begin
    int   id;
    int   g;
    rsp_t r;
    if (rst) begin
      acc_prev = 1'b0;
      have_acc = 1'b0;
    end else begin
      chk("op_start_after_accept", alu_op_start, acc_prev);
      acc_prev = 1'b0;
      if (req_ready != '0) begin
        id = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) id = i;
        chk("ready_onehot", $onehot(req_ready), 1);
        chk("ready_rsp_overlap", |rsp_valid, 0);
        if (exp_grant.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_grant: got=%0d want=none (cycle %0d)", id, cyc);
        end else begin
          g = exp_grant.pop_front();
          chk("grant_index", id, g);
        end
        if (spacing_on && have_acc) chk("accept_spacing", cyc - acc_cyc, LAT + 3);
        acc_cyc  = cyc;
        have_acc = 1'b1;
        acc_prev = 1'b1;
        n_accept++;
      end
      if (rsp_valid != '0) begin
        if (exp_rsp.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got=%0h want=none (cycle %0d)", rsp_valid, cyc);
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_valid_index", rsp_valid, 32'(1) << r.idx);
          chk("rsp_result", rsp_result, r.res);
          chk("grant_id_out", grant_id, r.idx);
          chk("rsp_latency", cyc - acc_cyc, LAT + 2);
          chk("rsp_ready_overlap", |req_ready, 0);
        end
      end
    end
  end

  task automatic wait_accept(input int target);
    int budget;
    budget = 50;
    while (n_accept < target && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (n_accept < target) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got=%0d want=%0d", n_accept, target);
    end
    #1;
  endtask

  task automatic drain();
    int budget;
    budget = 80;
    while ((exp_rsp.size() != 0 || exp_grant.size() != 0) && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_rsp.size() != 0 || exp_grant.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got=%0d/%0d pending want=0/0",
               exp_grant.size(), exp_rsp.size());
      exp_rsp.delete();
      exp_grant.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_op_start", alu_op_start, 0);
    chk("rst_alu_operation", alu_operation, 0);
    chk("rst_alu_operand_a", alu_operand_a, 0);
    chk("rst_alu_operand_b", alu_operand_b, 0);
    @(posedge clk);
    #1;

    // Single ADD: 200 + 100 = 300
    push(0, 16'h012C);
    set_req(0, 2'd0, 8'd200, 8'd100);
    wait_accept(1);
    req_valid[0] = 1'b0;
    chk("busy_after_accept", busy, 1);
    drain();

    // Masking: OR with junk upper byte, then full-width MUL
    push(2, 16'h00FF);
    set_req(2, 2'd2, 8'hF0, 8'h0F);
    wait_accept(2);
    req_valid[2] = 1'b0;
    drain();
    push(3, 16'hFE01);
    set_req(3, 2'd1, 8'd255, 8'd255);
    wait_accept(3);
    req_valid[3] = 1'b0;
    drain();
    chk("idle_keeps_operation", alu_operation, 1);
    chk("idle_keeps_operand_a", alu_operand_a, 8'd255);
    chk("idle_busy_low", busy, 0);

    // All four requesting continuously from reset: 0,1,2,3,0
    rst = 1'b1;
    set_req(0, 2'd0, 8'd1, 8'd2);
    set_req(1, 2'd1, 8'd16, 8'd16);
    set_req(2, 2'd3, 8'hCC, 8'hAA);
    set_req(3, 2'd0, 8'd255, 8'd255);
    push(0, 16'h0003);
    push(1, 16'h0100);
    push(2, 16'h0088);
    push(3, 16'h01FE);
    push(0, 16'h0003);
    spacing_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) wait_accept(3 + k);
    req_valid  = '0;
    spacing_on = 1'b0;
    drain();

    // Rotation: req 1 alone, then 0 and 3 rise together while 1 is in WAIT
    push(1, 16'h0052);
    set_req(1, 2'd2, 8'h12, 8'h40);
    wait_accept(9);
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    push(3, 16'h0030);
    push(0, 16'h009C);
    set_req(3, 2'd3, 8'hF0, 8'h3C);
    set_req(0, 2'd1, 8'd12, 8'd13);
    wait_accept(10);
    req_valid[3] = 1'b0;
    wait_accept(11);
    req_valid[0] = 1'b0;
    drain();

    // Reset while a MUL 12x12 is in WAIT: no response, then normal service
    exp_grant.push_back(2);
    set_req(2, 2'd1, 8'd12, 8'd12);
    wait_accept(12);
    req_valid[2] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_op_start", alu_op_start, 0);
    chk("midrst_rsp_result", rsp_result, 0);
    chk("midrst_grant_id", grant_id, 0);
    @(posedge clk);
    #1;
    push(1, 16'h0096);
    set_req(1, 2'd0, 8'd100, 8'd50);
    wait_accept(13);
    req_valid[1] = 1'b0;
    drain();

    // Withdrawn request: req 3 pulses valid only while busy
    push(0, 16'h0081);
    set_req(0, 2'd2, 8'h01, 8'h80);
    wait_accept(14);
    req_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    set_req(3, 2'd0, 8'd9, 8'd9);
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    drain();
    repeat (10) @(posedge clk);
    #1;
    chk("accept_count", n_accept, 14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
